// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Boot-time writer for the core's program memory. Consumes a framed byte
// stream from the serial receiver, assembles 16-bit instruction words (high
// byte first), and writes them sequentially from address 0. The core is held
// (o_run low) until a complete, valid image has been written.
//
// Frame: 0xA5 sync, LEN (word count, 0 = 256), LEN x {hi, lo}, [CSUM].
//
// Build option:
//   LOADER_CHECKSUM_EN  when defined, a trailing CSUM byte (sum mod 256 of LEN
//                       and all data bytes) is expected and checked; a
//                       mismatch aborts the load. When undefined, the last
//                       low byte completes the load directly.
//
// Parameters:
//   ADDR_WIDTH      program memory address width (>= 8)
//   TIMEOUT_CYCLES  idle cycles tolerated between bytes inside a frame
//
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_valid  one-cycle strobe, i_data holds a received byte
//   i_data   received byte
//   o_we     program-memory write enable (one-cycle pulse)
//   o_addr   write address
//   o_data   write data
//   o_run    core may run (held while low)
//   o_done   valid image loaded
//   o_error  last frame failed; cleared by the next sync byte
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic [7:0]            i_data,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [15:0]           o_data,
    output logic                  o_run,
    output logic                  o_done,
    output logic                  o_error
);

    localparam logic [7:0]       SYNC_BYTE = 8'hA5;
    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_HI,
        ST_LO,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t           state_reg;
    logic [7:0]       hi_reg;
    logic [8:0]       words_left_reg;   // 9 bits so that LEN = 0 can mean 256
    logic [CNT_W-1:0] idle_cnt_reg;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       sum_reg;
`endif

    // The idle counter only runs while a frame is being received.
    logic in_frame;
    assign in_frame = (state_reg == ST_LEN) || (state_reg == ST_HI) ||
                      (state_reg == ST_LO)  || (state_reg == ST_CSUM);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= ST_IDLE;
            hi_reg         <= '0;
            words_left_reg <= '0;
            idle_cnt_reg   <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_reg        <= '0;
`endif
            o_we           <= 1'b0;
            o_addr         <= '0;
            o_data         <= '0;
            o_run          <= 1'b0;
            o_done         <= 1'b0;
            o_error        <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse; the address moves on only
            // after the pulse so it is stable while o_we is high.
            o_we <= 1'b0;
            if (o_we) begin
                o_addr <= o_addr + ADDR_WIDTH'(1);
            end

            // Inter-byte timeout. The abort happens on the cycle after the
            // count has reached the limit, and only when no byte arrives.
            if (!in_frame || i_valid) begin
                idle_cnt_reg <= '0;
            end else if (idle_cnt_reg == CNT_LIMIT) begin
                idle_cnt_reg <= '0;
                state_reg    <= ST_ERROR;
                o_error      <= 1'b1;
                o_run        <= 1'b0;
            end else begin
                idle_cnt_reg <= idle_cnt_reg + CNT_W'(1);
            end

            case (state_reg)
                // Outside a frame only the sync byte matters; it also clears
                // a previous error, forcing a full reload.
                ST_IDLE, ST_ERROR: begin
                    if (i_valid && (i_data == SYNC_BYTE)) begin
                        state_reg <= ST_LEN;
                        o_error   <= 1'b0;
                    end
                end

                ST_LEN: begin
                    if (i_valid) begin
                        words_left_reg <= (i_data == 8'd0) ? 9'd256 : {1'b0, i_data};
                        o_addr         <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum_reg        <= i_data;
`endif
                        state_reg      <= ST_HI;
                    end
                end

                ST_HI: begin
                    if (i_valid) begin
                        hi_reg    <= i_data;
`ifdef LOADER_CHECKSUM_EN
                        sum_reg   <= sum_reg + i_data;
`endif
                        state_reg <= ST_LO;
                    end
                end

                ST_LO: begin
                    if (i_valid) begin
                        o_we           <= 1'b1;
                        o_data         <= {hi_reg, i_data};
                        words_left_reg <= words_left_reg - 9'd1;
`ifdef LOADER_CHECKSUM_EN
                        sum_reg        <= sum_reg + i_data;
`endif
                        if (words_left_reg == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
                            state_reg <= ST_CSUM;
`else
                            state_reg <= ST_DONE;
                            o_done    <= 1'b1;
                            o_run     <= 1'b1;
`endif
                        end else begin
                            state_reg <= ST_HI;
                        end
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (i_valid) begin
                        if (i_data == sum_reg) begin
                            state_reg <= ST_DONE;
                            o_done    <= 1'b1;
                            o_run     <= 1'b1;
                        end else begin
                            state_reg <= ST_ERROR;
                            o_error   <= 1'b1;
                            o_run     <= 1'b0;
                        end
                    end
                end
`endif

                // DONE ignores everything until reset.
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Directed and randomized frames are driven into program_loader; the expected
// write list and final outcome of each frame are derived from the frame
// format rules by a small parser model, and compared against writes captured
// from the DUT's write port.
// -----------------------------------------------------------------------------
module tb_program_loader;

    localparam int AW = 8;
    localparam int TO = 16;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif
    localparam int OUT_DONE  = 1;
    localparam int OUT_ERROR = 2;

    typedef logic [7:0]  byte_q_t [$];
    typedef logic [23:0] wr_q_t [$];   // {addr[7:0], data[15:0]}

    logic          i_clk   = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic [7:0]    i_data  = 8'h00;
    logic          o_we;
    logic [AW-1:0] o_addr;
    logic [15:0]   o_data;
    logic          o_run;
    logic          o_done;
    logic          o_error;

    int tests_run    = 0;
    int tests_failed = 0;

    wr_q_t         captured;
    logic          prev_we   = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [AW-1:0] next_addr;

    always #5 i_clk = ~i_clk;

    program_loader #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_we    (o_we),
        .o_addr  (o_addr),
        .o_data  (o_data),
        .o_run   (o_run),
        .o_done  (o_done),
        .o_error (o_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write-port monitor: captures every write, checks the pulse is one cycle
    // wide and that the address steps by one right after each pulse.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prev_we = 1'b0;
        end else begin
            if (prev_we) begin
                next_addr = prev_addr + AW'(1);
                chk("addr_advance", 32'(o_addr), 32'(next_addr));
            end
            if (o_we) begin
                chk("we_single_cycle", 32'(prev_we), 32'd0);
                captured.push_back({o_addr, o_data});
            end
            prev_we   = o_we;
            prev_addr = o_addr;
        end
    end

    // Reference parser: skip to the first sync byte, then apply the frame
    // rules to predict the writes and whether the load succeeds.
    function automatic void ref_model(input byte_q_t s, output wr_q_t w, output int outcome);
        int p;
        int n;
        int sum;
        w = {};
        p = 0;
        while (p < s.size() && s[p] != 8'hA5) p++;
        p++;
        n   = (s[p] == 8'h00) ? 256 : int'(s[p]);
        sum = int'(s[p]);
        p++;
        for (int i = 0; i < n; i++) begin
            w.push_back({i[7:0], s[p], s[p+1]});
            sum = sum + int'(s[p]) + int'(s[p+1]);
            p = p + 2;
        end
        outcome = OUT_DONE;
        if (CSUM_EN && ((sum % 256) != int'(s[p]))) outcome = OUT_ERROR;
    endfunction

    function automatic byte_q_t build_frame(input byte_q_t body, input bit corrupt);
        byte_q_t    f;
        logic [7:0] s;
        s = 8'h00;
        f.push_back(8'hA5);
        foreach (body[k]) begin
            f.push_back(body[k]);
            s = s + body[k];
        end
        if (CSUM_EN) f.push_back(corrupt ? (s + 8'd1) : s);
        return f;
    endfunction

    // Drives each byte with a random idle gap before it; returns at the
    // falling edge one clock after the last byte was sampled.
    task automatic send_stream(input byte_q_t s, input int max_gap);
        foreach (s[k]) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (g) begin
                @(negedge i_clk);
                i_valid = 1'b0;
            end
            @(negedge i_clk);
            i_valid = 1'b1;
            i_data  = s[k];
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        i_data  = 8'h00;
    endtask

    task automatic check_writes(input string tag, input wr_q_t exp_w);
        chk({tag, "_nwrites"}, 32'(captured.size()), 32'(exp_w.size()));
        foreach (exp_w[k]) begin
            if (k < captured.size())
                chk($sformatf("%s_w%0d", tag, k), 32'(captured[k]), 32'(exp_w[k]));
        end
    endtask

    task automatic run_frame(input string tag, input byte_q_t s, input int max_gap);
        wr_q_t exp_w;
        int    outcome;
        ref_model(s, exp_w, outcome);
        captured.delete();
        send_stream(s, max_gap);
        chk({tag, "_done"},  32'(o_done),  32'(outcome == OUT_DONE));
        chk({tag, "_run"},   32'(o_run),   32'(outcome == OUT_DONE));
        chk({tag, "_error"}, 32'(o_error), 32'(outcome == OUT_ERROR));
        repeat (2) @(negedge i_clk);
        check_writes(tag, exp_w);
        $display("[TB] frame %s: %0d bytes, %0d writes, done=%0b error=%0b",
                 tag, s.size(), captured.size(), o_done, o_error);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"},    32'(o_we),    32'd0);
        chk({tag, "_addr"},  32'(o_addr),  32'd0);
        chk({tag, "_data"},  32'(o_data),  32'd0);
        chk({tag, "_run"},   32'(o_run),   32'd0);
        chk({tag, "_done"},  32'(o_done),  32'd0);
        chk({tag, "_error"}, 32'(o_error), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check_reset_outputs("reset");
        i_rst_n = 1'b1;
    endtask

    initial begin
        byte_q_t f;
        byte_q_t g;
        byte_q_t body;
        byte_q_t noise;
        wr_q_t   exp_w;
        int      outcome;
        int      len;
        bit      corrupt;
        logic [7:0] nb;

        repeat (2) @(negedge i_clk);
        check_reset_outputs("reset");
        i_rst_n = 1'b1;

        // Nominal two-word load, then a second frame that must be ignored.
        body = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        f = build_frame(body, 1'b0);
        run_frame("nominal", f, 0);
        body = '{8'h01, 8'hDE, 8'hAD};
        f = build_frame(body, 1'b0);
        captured.delete();
        send_stream(f, 0);
        repeat (2) @(negedge i_clk);
        chk("after_done_nwrites", 32'(captured.size()), 32'd0);
        chk("after_done_done", 32'(o_done), 32'd1);
        $display("[TB] frame after_done: ignored, %0d writes", captured.size());

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum, then resync and reload without reset.
        do_reset();
        body = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        f = build_frame(body, 1'b1);
        run_frame("bad_csum", f, 1);
        g = build_frame(body, 1'b0);
        f = '{8'hA5};
        captured.delete();
        send_stream(f, 0);
        chk("resync_error_clear", 32'(o_error), 32'd0);
        chk("resync_run_low", 32'(o_run), 32'd0);
        f = g[1:$];
        send_stream(f, 0);
        chk("reload_done", 32'(o_done), 32'd1);
        chk("reload_run", 32'(o_run), 32'd1);
        repeat (2) @(negedge i_clk);
        ref_model(g, exp_w, outcome);
        check_writes("reload", exp_w);
        $display("[TB] frame reload: %0d writes, done=%0b", captured.size(), o_done);
`endif

        // Preamble noise and 0xA5 used as data.
        do_reset();
        body = '{8'h01, 8'hA5, 8'hA5};
        g = build_frame(body, 1'b0);
        f = '{8'hFF, 8'h00};
        foreach (g[k]) f.push_back(g[k]);
        run_frame("noise_a5data", f, 2);

        // Timeout inside a frame.
        do_reset();
        captured.delete();
        f = '{8'hA5, 8'h01, 8'h12};
        send_stream(f, 0);
        repeat (14) @(negedge i_clk);
        chk("timeout_early_error", 32'(o_error), 32'd0);
        repeat (3) @(negedge i_clk);
        chk("timeout_error", 32'(o_error), 32'd1);
        chk("timeout_run", 32'(o_run), 32'd0);
        chk("timeout_done", 32'(o_done), 32'd0);
        chk("timeout_nwrites", 32'(captured.size()), 32'd0);
        $display("[TB] frame timeout: error=%0b writes=%0d", o_error, captured.size());

        // Full depth, back-to-back bytes.
        do_reset();
        body = '{8'h00};
        for (int n = 0; n < 256; n++) begin
            body.push_back(8'h00);
            body.push_back(n[7:0]);
        end
        f = build_frame(body, 1'b0);
        run_frame("full_depth", f, 0);

        // Asynchronous reset in the middle of a frame.
        do_reset();
        captured.delete();
        f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
        send_stream(f, 0);
        chk("midframe_data", 32'(o_data), 32'h1122);
        chk("midframe_addr", 32'(o_addr), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        body = '{8'h02, 8'h55, 8'h66, 8'h77, 8'h88};
        f = build_frame(body, 1'b0);
        run_frame("after_reset", f, 2);

        // Randomized frames with noise, gaps and (when enabled) bad checksums.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            noise = {};
            repeat ($urandom_range(3, 0)) begin
                nb = 8'($urandom);
                if (nb == 8'hA5) nb = 8'h5A;
                noise.push_back(nb);
            end
            len  = int'($urandom_range(24, 1));
            body = '{8'(len)};
            for (int k = 0; k < 2 * len; k++) body.push_back(8'($urandom));
            corrupt = CSUM_EN && ($urandom_range(3, 0) == 0);
            g = build_frame(body, corrupt);
            f = noise;
            foreach (g[k]) f.push_back(g[k]);
            run_frame($sformatf("random%0d", r), f, 5);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

endmodule
